// File: rtl/sub_serial.sv
// sub_serial: bit-serial subtractor computing a - b, LSB first, one bit per
// clock. A single borrow flop is propagated from bit to bit. The result is
// packed as {borrow, diff}, matching the adder's {carry, sum} layout.
//
// Ports:
//   clk    - rising-edge clock
//   rst    - synchronous active-high reset; overrides everything else
//   start  - request an operation; sampled only in IDLE or DONE
//   a, b   - minuend / subtrahend; captured when start is accepted
//   busy   - high while bits are being processed
//   done   - one-cycle pulse; out / b_out / ovf have just been updated
//   out    - {b_out, diff}, where diff = (a - b) mod 2^WIDTH
//   b_out  - final borrow; set when a < b as unsigned values
//   ovf    - signed overflow, computed from the captured operand MSBs
module sub_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   out,
  output logic             b_out,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nx_s;
  logic             accept_s;

  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] res_r;
  logic             borrow_r;
  logic [CNT_W-1:0] cnt_r;
  logic             a_msb_r;
  logic             b_msb_r;

  logic             busy_r;
  logic             done_r;
  logic [WIDTH:0]   out_r;
  logic             b_out_r;
  logic             ovf_r;

  logic             ai_s;
  logic             bi_s;
  logic             d_s;
  logic             bnext_s;
  logic             last_s;
  logic [WIDTH-1:0] diff_s;

  // One-bit full-subtractor cell on the current operand LSBs.
  always_comb begin
    ai_s    = a_sh_r[0];
    bi_s    = b_sh_r[0];
    d_s     = ai_s ^ bi_s ^ borrow_r;
    bnext_s = (~ai_s & bi_s) | (~(ai_s ^ bi_s) & borrow_r);
    last_s  = (cnt_r == LAST_BIT);
    // The final difference bit enters at the MSB on the last RUN cycle,
    // so the complete result is visible combinationally one edge early.
    diff_s  = {d_s, res_r[WIDTH-1:1]};
  end

  // Next-state decode and start acceptance.
  always_comb begin
    state_nx_s = state_r;
    accept_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nx_s = ST_RUN;
          accept_s   = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_s) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_nx_s = ST_RUN;
          accept_s   = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Operand shifters, borrow flop, bit counter and result latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_r   <= '0;
      b_sh_r   <= '0;
      res_r    <= '0;
      borrow_r <= 1'b0;
      cnt_r    <= '0;
      a_msb_r  <= 1'b0;
      b_msb_r  <= 1'b0;
      out_r    <= '0;
      b_out_r  <= 1'b0;
      ovf_r    <= 1'b0;
    end else if (accept_s) begin
      a_sh_r   <= a;
      b_sh_r   <= b;
      res_r    <= '0;
      borrow_r <= 1'b0;
      cnt_r    <= '0;
      a_msb_r  <= a[WIDTH-1];
      b_msb_r  <= b[WIDTH-1];
    end else if (state_r == ST_RUN) begin
      a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
      b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
      res_r    <= diff_s;
      borrow_r <= bnext_s;
      cnt_r    <= cnt_r + CNT_W'(1);
      if (last_s) begin
        out_r   <= {bnext_s, diff_s};
        b_out_r <= bnext_s;
        // Overflow only when operand signs differ and the result sign
        // disagrees with the minuend.
        ovf_r   <= (a_msb_r ^ b_msb_r) & (d_s ^ a_msb_r);
      end
    end
  end

  // Status flags registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_nx_s == ST_RUN);
      done_r <= (state_nx_s == ST_DONE);
    end
  end

  assign busy  = busy_r;
  assign done  = done_r;
  assign out   = out_r;
  assign b_out = b_out_r;
  assign ovf   = ovf_r;

endmodule

// File: doc/sub_serial.md
# sub_serial

Bit-serial unsigned/two's-complement subtractor, the counterpart to the ripple-carry adder in the CPU datapath. Computes `a - b` one bit per clock, LSB first, propagating a borrow flip-flop in place of the adder's carry chain. Result format mirrors the adder's `{carry, sum}` packing as `{borrow, diff}`. The ALU uses it for SUB/CMP where area matters more than latency, with a start/done handshake.

## Interface
Parameters:
- `WIDTH`, default 8: operand width in bits; must be at least 2.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `start`, input, 1: request a subtraction; sampled only in IDLE or DONE.
- `a`, input, WIDTH: minuend; captured on an accepted `start`.
- `b`, input, WIDTH: subtrahend; captured on an accepted `start`.
- `busy`, output, 1: high while bits are being processed (RUN).
- `done`, output, 1: one-cycle pulse; marks `out`, `b_out` and `ovf` as newly valid.
- `out`, output, WIDTH+1: `{b_out, diff}`, where `diff = (a - b) mod 2^WIDTH`.
- `b_out`, output, 1: final borrow; 1 iff `a < b` as unsigned values.
- `ovf`, output, 1: signed overflow; `a[MSB] != b[MSB]` and `diff[MSB] != a[MSB]`.

## Operation
- States:
  - IDLE: `busy=0`, `done=0`.
  - RUN: `busy=1`.
  - DONE: `done=1`, one cycle only.
- Transitions:
  - IDLE and `start`: capture `a` and `b` into shift registers, clear the borrow flop, set bit counter to 0, go to RUN.
  - RUN: each cycle process one bit, with `ai`/`bi` = current LSBs of the shift registers.
    - `d = ai ^ bi ^ bin`
    - `bnext = (~ai & bi) | (~(ai ^ bi) & bin)`
    - Shift `d` into the result register from the MSB end, shift the operand registers right, increment the counter.
    - After bit WIDTH-1 is processed, latch `out`, `b_out` and `ovf`, go to DONE.
  - DONE: if `start` is high, capture new operands and go to RUN (back-to-back). Otherwise go to IDLE.
- `start` is ignored in RUN. Operands are not re-sampled and the running operation is unaffected.
- `a` and `b` need only be stable in the cycle `start` is accepted.
- `out`, `b_out` and `ovf` hold their last result until the next completion. They do not change during RUN.
- `ovf` uses the captured operand MSBs, not the live inputs.
- All arithmetic is modulo 2^WIDTH. Borrow-in for bit 0 is always 0.

## Timing
- Reset values: `busy=0`, `done=0`, `out=0`, `b_out=0`, `ovf=0`, state IDLE, counter 0.
- `rst` dominates everything, including mid-RUN and in DONE. The partial result is discarded and outputs return to reset values at the next edge.
- For `start` sampled at edge k in IDLE:
  - `busy` is high in cycles k+1 through k+WIDTH.
  - At edge k+WIDTH the results update, `done=1` and `busy=0`, for cycle k+WIDTH+1 only.
- Latency: WIDTH+1 edges from `start` to `done` visible.
- Throughput: one result per WIDTH+1 cycles with `start` held high continuously. `start` is accepted in the DONE cycle.
- `busy` and `done` are never high together.
- `start` and `rst` in the same cycle: reset wins and the start is dropped.

## Test plan
- Reset, then 0x50 - 0x20 (WIDTH=8): `busy` high for exactly 8 cycles, then a single `done` pulse with `out=0x030`, `b_out=0`, `ovf=0`.
- 0x20 - 0x50: `out=0x1D0`, `b_out=1`, `ovf=0`. Also 0x00 - 0x01: `out=0x1FF`, `b_out=1`.
- Signed overflow:
  - 0x80 - 0x01: `out=0x07F`, `ovf=1`, `b_out=0`.
  - 0x7F - 0xFF: `out=0x180`, `ovf=1`, `b_out=1`.
  - 0x05 - 0x05: `out=0x000`, `ovf=0`.
- Start 0x10 - 0x01, then pulse `start` with 0xFF/0xFF and change `a`/`b` during RUN: result is `out=0x00F` with one `done` pulse; the second start is ignored.
- `start` held high across three operations (0x03-0x01, 0x01-0x03, 0xAA-0x55): `done` pulses every 9 cycles, in order:
  - 0x03 - 0x01: `out=0x002`.
  - 0x01 - 0x03: `out=0x1FE`.
  - 0xAA - 0x55: `out=0x055`, `ovf=1`.
- Assert `rst` on the 4th RUN cycle of 0x20 - 0x50: next cycle all outputs are 0 and state is IDLE. A fresh 0x09 - 0x04 then gives `out=0x005` with correct timing.
